// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch RUN/PAUSED/ADJ mode controller with mm:ss BCD time and blink qualifiers
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK_REF,
  input  logic       CLK_RES,
  input  logic       TICK_1HZ,
  input  logic       TICK_2HZ,
  input  logic       BTN_PAUSE,
  input  logic       BTN_ADJ,
  input  logic       BTN_SEL,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_O,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_O,
  output logic       BLINK_MIN,
  output logic       BLINK_SEC,
  output logic       RUNNING
);

  typedef enum logic [1:0] {
    S_PAUSED = 2'd0,
    S_RUN    = 2'd1,
    S_ADJ    = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] min_q;
  logic [7:0] sec_q;
  logic       sel_sec;
  logic       phase;

  // Bit order in every vector below: {sel, adj, pause}.
  logic [2:0] btn_raw;
  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] hist_q;
  logic [2:0] press;
  logic       press_pause;
  logic       press_adj;
  logic       press_sel;

  assign btn_raw = {BTN_SEL, BTN_ADJ, BTN_PAUSE};

  // Sync and history flops reset high so a button held through reset never reads as a press.
  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b111;
      hist_q <= 3'b111;
    end else begin
      sync_q[0] <= btn_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press       = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign press_pause = press[0];
  assign press_adj   = press[1];
  assign press_sel   = press[2];

  // Two-digit BCD increment modulo 60: {tens, ones}.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o == 4'd9) begin
      o = 4'd0;
      t = (t == 4'd5) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  always_ff @(posedge CLK_REF or posedge CLK_RES) begin
    if (CLK_RES) begin
      state   <= S_PAUSED;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      sel_sec <= 1'b0;
      phase   <= 1'b0;
    end else begin
      case (state)
        S_PAUSED: begin
          if (press_adj) begin
            state   <= S_ADJ;
            sel_sec <= 1'b0;
            phase   <= 1'b0;
          end else if (press_pause) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (TICK_1HZ) begin
            sec_q <= inc60(sec_q);
            if (sec_q == 8'h59) min_q <= inc60(min_q);
          end
          if (press_adj) begin
            state   <= S_ADJ;
            sel_sec <= 1'b0;
            phase   <= 1'b0;
          end else if (press_pause) begin
            state <= S_PAUSED;
          end
        end
        S_ADJ: begin
          if (TICK_2HZ) begin
            if (sel_sec) sec_q <= inc60(sec_q);
            else         min_q <= inc60(min_q);
            phase <= ~phase;
          end
          if (press_sel) sel_sec <= ~sel_sec;
          // Leaving ADJ overrides any phase toggle from a coincident tick.
          if (press_adj) begin
            state <= S_PAUSED;
            phase <= 1'b0;
          end
        end
        default: state <= S_PAUSED;
      endcase
    end
  end

  assign MIN_T     = min_q[7:4];
  assign MIN_O     = min_q[3:0];
  assign SEC_T     = sec_q[7:4];
  assign SEC_O     = sec_q[3:0];
  assign RUNNING   = (state == S_RUN);
  assign BLINK_MIN = (state == S_ADJ) && !sel_sec && phase;
  assign BLINK_SEC = (state == S_ADJ) &&  sel_sec && phase;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick1 = 1'b0;
  logic       tick2 = 1'b0;
  logic       b_pause = 1'b0;
  logic       b_adj = 1'b0;
  logic       b_sel = 1'b0;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic       blink_min, blink_sec, running;
  logic [15:0] tm;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
    .CLK_REF   (clk),
    .CLK_RES   (rst),
    .TICK_1HZ  (tick1),
    .TICK_2HZ  (tick2),
    .BTN_PAUSE (b_pause),
    .BTN_ADJ   (b_adj),
    .BTN_SEL   (b_sel),
    .MIN_T     (min_t),
    .MIN_O     (min_o),
    .SEC_T     (sec_t),
    .SEC_O     (sec_o),
    .BLINK_MIN (blink_min),
    .BLINK_SEC (blink_sec),
    .RUNNING   (running)
  );

  assign tm = {min_t, min_o, sec_t, sec_o};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick1_pulse();
    @(negedge clk) tick1 = 1'b1;
    @(negedge clk) tick1 = 1'b0;
  endtask

  task automatic tick2_pulse();
    @(negedge clk) tick2 = 1'b1;
    @(negedge clk) tick2 = 1'b0;
  endtask

  task automatic press(input logic p, input logic a, input logic s);
    @(negedge clk);
    b_pause = p; b_adj = a; b_sel = s;
    repeat (4) @(negedge clk);
    b_pause = 1'b0; b_adj = 1'b0; b_sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    // 1: reset state, run 61 seconds
    do_reset();
    check("reset_time", tm, 16'h0000);
    check("reset_running", {15'd0, running}, 16'd0);
    check("reset_blink", {14'd0, blink_min, blink_sec}, 16'd0);
    press(1, 0, 0);
    check("run_after_pause", {15'd0, running}, 16'd1);
    for (int i = 0; i < 61; i++) tick1_pulse();
    check("t1_time_0101", tm, 16'h0101);
    check("t1_running", {15'd0, running}, 16'd1);

    // 2: preload 59:59 through ADJ, then wrap
    press(0, 1, 0);
    check("t2_adj_not_running", {15'd0, running}, 16'd0);
    for (int i = 0; i < 58; i++) tick2_pulse();
    check("t2_min59", tm, 16'h5901);
    press(0, 0, 1);
    for (int i = 0; i < 58; i++) tick2_pulse();
    check("t2_preload", tm, 16'h5959);
    press(0, 1, 0);
    press(1, 0, 0);
    check("t2_running", {15'd0, running}, 16'd1);
    check("t2_blink_off", {14'd0, blink_min, blink_sec}, 16'd0);
    tick1_pulse();
    check("t2_wrap", tm, 16'h0000);

    // 3: minute adjust with blink, then seconds
    press(1, 0, 0);
    check("t3_paused", {15'd0, running}, 16'd0);
    press(0, 1, 0);
    check("t3_blink_start", {14'd0, blink_min, blink_sec}, 16'd0);
    tick2_pulse();
    check("t3_min1", tm, 16'h0100);
    check("t3_blink1", {14'd0, blink_min, blink_sec}, 16'b10);
    tick2_pulse();
    check("t3_min2", tm, 16'h0200);
    check("t3_blink2", {14'd0, blink_min, blink_sec}, 16'b00);
    tick2_pulse();
    check("t3_min3", tm, 16'h0300);
    check("t3_blink3", {14'd0, blink_min, blink_sec}, 16'b10);
    press(0, 0, 1);
    check("t3_blink_sel_sec", {14'd0, blink_min, blink_sec}, 16'b01);
    for (int i = 0; i < 58; i++) tick2_pulse();
    check("t3_sec58", tm, 16'h0358);
    check("t3_blink_end", {14'd0, blink_min, blink_sec}, 16'b01);

    // 4: ADJ+PAUSE together from RUN, PAUSE ignored in ADJ
    press(0, 1, 0);
    press(1, 0, 0);
    check("t4_run", {15'd0, running}, 16'd1);
    press(1, 1, 0);
    check("t4_adj_wins", {15'd0, running}, 16'd0);
    tick2_pulse();
    check("t4_in_adj_min", tm, 16'h0458);
    check("t4_blink", {14'd0, blink_min, blink_sec}, 16'b10);
    press(1, 0, 0);
    check("t4_pause_ignored", {15'd0, running}, 16'd0);
    tick2_pulse();
    check("t4_still_adj", tm, 16'h0558);

    // 5: tick coincident with pause press at 00:09
    do_reset();
    press(0, 1, 0);
    press(0, 0, 1);
    for (int i = 0; i < 9; i++) tick2_pulse();
    press(0, 1, 0);
    press(1, 0, 0);
    check("t5_start", tm, 16'h0009);
    check("t5_running", {15'd0, running}, 16'd1);
    @(negedge clk) b_pause = 1'b1;
    @(negedge clk);
    @(negedge clk) tick1 = 1'b1;
    @(negedge clk) tick1 = 1'b0;
    check("t5_time_10", tm, 16'h0010);
    check("t5_paused", {15'd0, running}, 16'd0);
    repeat (2) @(negedge clk);
    b_pause = 1'b0;
    tick1_pulse();
    tick1_pulse();
    check("t5_held", tm, 16'h0010);

    // 6: button held through reset, then async reset mid-RUN
    @(negedge clk);
    b_adj = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    b_adj = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_not_running", {15'd0, running}, 16'd0);
    tick2_pulse();
    check("t6_not_adj_time", tm, 16'h0000);
    check("t6_not_adj_blink", {14'd0, blink_min, blink_sec}, 16'd0);
    press(1, 0, 0);
    tick1_pulse();
    check("t6_run_time", tm, 16'h0001);
    check("t6_run", {15'd0, running}, 16'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_time", tm, 16'h0000);
    check("t6_async_running", {15'd0, running}, 16'd0);
    check("t6_async_blink", {14'd0, blink_min, blink_sec}, 16'd0);
    @(negedge clk) rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
